// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and helpers.
//   - NR_AES128/192/256 : legal round counts
//   - fsm_state_t       : engine control states
//   - sbox()            : forward S-box lookup
//   - gf_mul2/gf_mul3   : GF(2^8) multiply by 2 and by 3
//   - byte_idx/get_byte : column-major state byte addressing (byte 0 = bits 127:120)
//   - mix_column()      : MixColumns on one 32-bit column (row 0 in the top byte)
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // Entry 0x00 occupies the top byte, so entry b sits at bit {~b, 3'b111}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    gf_mul2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    gf_mul3 = gf_mul2(b) ^ b;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    byte_idx = 4 * col + row;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
    get_byte = s[127 - 8 * idx -: 8];
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                  a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                  a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                  gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES encryption round.
//   st       in  128  current state
//   rk       in  128  round key
//   is_final in  1    final round: MixColumns skipped
//   next_st  out 128  SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         is_final,
  output logic [127:0] next_st
);

  logic [127:0] sr_s;
  logic [127:0] mc_s;

  // SubBytes fused with ShiftRows: row r of column c takes the byte from column (c+r) mod 4
  always_comb begin
    sr_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127 - 8 * byte_idx(r, c) -: 8] = sbox(get_byte(st, byte_idx(r, (c + r) % 4)));
      end
    end
  end

  // MixColumns applied column by column
  always_comb begin
    mc_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      mc_s[127 - 32 * c -: 32] = mix_column(sr_s[127 - 32 * c -: 32]);
    end
  end

  // AddRoundKey on either the mixed or the unmixed state
  always_comb begin
    if (is_final) begin
      next_st = sr_s ^ rk;
    end else begin
      next_st = mc_s ^ rk;
    end
  end

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption, one round per clock.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   plaintext handshake, data_in 128-bit
//   rk_idx/rk_in        round-key request; rk_in must be valid in the same cycle
//   out_valid/out_ready ciphertext handshake, data_out 128-bit (driven from state always)
//   busy                high while rounds are executing
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_round_engine: RK_IDX_W too narrow for NR");
  end

  localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RND_ONE = RK_IDX_W'(1);

  fsm_state_t          fsm_r;
  logic [127:0]        st_r;
  logic [RK_IDX_W-1:0] rnd_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                accept_s;
  logic                is_final_s;
  logic [127:0]        round_next_s;

  assign is_final_s = (rnd_r == NR_IDX);
  assign accept_s   = in_valid & in_ready;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign data_out   = st_r;

  aes_round_comb u_round (
    .st       (st_r),
    .rk       (rk_in),
    .is_final (is_final_s),
    .next_st  (round_next_s)
  );

  // Handshake and key-index decode; DONE forwards out_ready so a drain and a load share a cycle
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = {RK_IDX_W{1'b0}};
    case (fsm_r)
      ST_IDLE: in_ready = ~rst;
      ST_RUN:  rk_idx   = rnd_r;
      ST_DONE: in_ready = out_ready & ~rst;
      default: in_ready = 1'b0;
    endcase
  end

  // Control FSM, round counter and state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= ST_IDLE;
      st_r        <= 128'h0;
      rnd_r       <= {RK_IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (accept_s) begin
            st_r   <= data_in ^ rk_in;
            rnd_r  <= RND_ONE;
            fsm_r  <= ST_RUN;
            busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          st_r <= round_next_s;
          if (is_final_s) begin
            // Counter parks at 0 so rk_idx never runs past NR
            rnd_r       <= {RK_IDX_W{1'b0}};
            fsm_r       <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            rnd_r <= rnd_r + RND_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              st_r   <= data_in ^ rk_in;
              rnd_r  <= RND_ONE;
              fsm_r  <= ST_RUN;
              busy_r <= 1'b1;
            end else begin
              fsm_r <= ST_IDLE;
            end
          end
        end
        default: begin
          fsm_r       <= ST_IDLE;
          st_r        <= 128'h0;
          rnd_r       <= {RK_IDX_W{1'b0}};
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed-vector bench for aes_round_engine (NR=10 main
// instance, plus NR=12 and NR=14 instances for the key-size vectors).
module tb_aes_round_engine;
  import aes_pkg::*;

  typedef logic [15:0][127:0] rk_tab_t;

  localparam logic [127:0] APB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] APB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] STD_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in, rk_in, data_out;
  logic [3:0] rk_idx;
  logic iv12, ir12, ov12, or12, busy12, iv14, ir14, ov14, or14, busy14;
  logic [127:0] di12, rk12_in, do12, di14, rk14_in, do14;
  logic [3:0] rki12, rki14;
  rk_tab_t rk10_tab, rk12_tab, rk14_tab, apb_rk, std10_rk, std12_rk, std14_rk;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_round_engine #(.NR(10), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .rk_idx(rk_idx), .rk_in(rk_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy));
  aes_round_engine #(.NR(12), .RK_IDX_W(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .data_in(di12),
    .rk_idx(rki12), .rk_in(rk12_in), .out_valid(ov12), .out_ready(or12),
    .data_out(do12), .busy(busy12));
  aes_round_engine #(.NR(14), .RK_IDX_W(4)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .data_in(di14),
    .rk_idx(rki14), .rk_in(rk14_in), .out_valid(ov14), .out_ready(or14),
    .data_out(do14), .busy(busy14));

  // Combinational key store served by the bench
  always_comb begin
    rk_in   = rk10_tab[rk_idx];
    rk12_in = rk12_tab[rki12];
    rk14_in = rk14_tab[rki14];
  end

  // FIPS-197 key expansion; key left-aligned in 256 bits, nk = 4/6/8 words
  function automatic rk_tab_t expand(input logic [255:0] key, input int nk);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0] rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gf_mul2(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      expand[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'h0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block on the main instance for a single accepting edge (caller ensures idle)
  task automatic send_block(input logic [127:0] pt);
    data_in  = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data_out !== 128'h0) begin failures++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    checks++; if (rk_idx !== 4'd0) begin failures++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fips_b();
    rk10_tab  = apb_rk;
    out_ready = 1'b0;
    data_in   = APB_PT;
    in_valid  = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || rk_idx !== 4'd0) begin failures++; $display("FAIL fips_idle: in_ready=%b rk_idx=%0d expected 1/0", in_ready, rk_idx); end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (rk_idx !== 4'(i) || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL fips_run[%0d]: rk_idx=%0d busy=%b out_valid=%b in_ready=%b expected %0d/1/0/0", i, rk_idx, busy, out_valid, in_ready, i);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fips_latency: out_valid=%b expected 1 at 11 cycles", out_valid); end
    checks++; if (data_out !== APB_CT) begin failures++; $display("FAIL fips_ct: got %h expected %h", data_out, APB_CT); end
    checks++; if (rk_idx !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL fips_done: rk_idx=%0d busy=%b expected 0/0", rk_idx, busy); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL fips_drain: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_key_sizes();
    bit g10, g12, g14;
    int l10, l12, l14;
    logic [127:0] d10, d12, d14;
    g10 = 1'b0; g12 = 1'b0; g14 = 1'b0;
    l10 = 0; l12 = 0; l14 = 0;
    d10 = 128'h0; d12 = 128'h0; d14 = 128'h0;
    rk10_tab = std10_rk;
    rk12_tab = std12_rk;
    rk14_tab = std14_rk;
    data_in = STD_PT; di12 = STD_PT; di14 = STD_PT;
    in_valid = 1'b1; iv12 = 1'b1; iv14 = 1'b1;
    #1;
    checks++; if (ir12 !== 1'b1 || ir14 !== 1'b1) begin failures++; $display("FAIL keysz_ready: ir12=%b ir14=%b expected 1/1", ir12, ir14); end
    tick();
    in_valid = 1'b0; iv12 = 1'b0; iv14 = 1'b0;
    checks++; if (busy12 !== 1'b1 || busy14 !== 1'b1) begin failures++; $display("FAIL keysz_busy: busy12=%b busy14=%b expected 1/1", busy12, busy14); end
    for (int n = 1; n <= 20; n++) begin
      if (out_valid === 1'b1 && !g10) begin g10 = 1'b1; l10 = n; d10 = data_out; end
      if (ov12 === 1'b1 && !g12) begin g12 = 1'b1; l12 = n; d12 = do12; end
      if (ov14 === 1'b1 && !g14) begin g14 = 1'b1; l14 = n; d14 = do14; end
      tick();
    end
    checks++; if (l10 != 11) begin failures++; $display("FAIL nr10_latency: got %0d expected 11", l10); end
    checks++; if (d10 !== CT128) begin failures++; $display("FAIL nr10_ct: got %h expected %h", d10, CT128); end
    checks++; if (l12 != 13) begin failures++; $display("FAIL nr12_latency: got %0d expected 13", l12); end
    checks++; if (d12 !== CT192) begin failures++; $display("FAIL nr12_ct: got %h expected %h", d12, CT192); end
    checks++; if (l14 != 15) begin failures++; $display("FAIL nr14_latency: got %0d expected 15", l14); end
    checks++; if (d14 !== CT256) begin failures++; $display("FAIL nr14_ct: got %h expected %h", d14, CT256); end
    out_ready = 1'b1; or12 = 1'b1; or14 = 1'b1;
    tick();
    out_ready = 1'b0; or12 = 1'b0; or14 = 1'b0;
  endtask

  task automatic test_backpressure();
    bit got;
    bit extra;
    rk10_tab  = apb_rk;
    out_ready = 1'b0;
    send_block(APB_PT);
    wait_out(15, got);
    checks++; if (!got) begin failures++; $display("FAIL bp_timeout: out_valid not seen within 15 cycles"); end
    // Source offers another block the whole time; it must be ignored until drained
    data_in  = STD_PT;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== APB_CT || in_ready !== 1'b0 || rk_idx !== 4'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b data_out=%h in_ready=%b rk_idx=%0d busy=%b expected 1/%h/0/0/0", i, out_valid, data_out, in_ready, rk_idx, busy, APB_CT);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_handoff: out_valid=%b busy=%b expected 0/0", out_valid, busy); end
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) extra = 1'b1;
      tick();
    end
    checks++; if (extra) begin failures++; $display("FAIL bp_single_handoff: got extra out_valid expected none"); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int outs, acc, last;
    bit will_accept;
    outs = 0; acc = 0; last = 0;
    rk10_tab  = apb_rk;
    data_in   = APB_PT;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    for (int cyc = 0; cyc < 80 && outs < 4; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++; if (data_out !== APB_CT) begin failures++; $display("FAIL b2b_ct[%0d]: got %h expected %h", outs, data_out, APB_CT); end
        if (outs == 0) begin
          checks++; if (cyc != 11) begin failures++; $display("FAIL b2b_first: got cycle %0d expected 11", cyc); end
        end else begin
          checks++; if (cyc - last != 11) begin failures++; $display("FAIL b2b_interval[%0d]: got %0d expected 11", outs, cyc - last); end
        end
        last = cyc;
        outs++;
      end
      will_accept = in_valid & in_ready;
      tick();
      if (will_accept) begin
        acc++;
        if (acc == 4) in_valid = 1'b0;
      end
    end
    checks++; if (outs != 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", outs); end
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle: busy=%b out_valid=%b in_ready=%b expected 0/0/1", busy, out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    bit got;
    bit reached;
    rk10_tab = apb_rk;
    send_block(APB_PT);
    reached = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (rk_idx === 4'd5) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!reached) begin failures++; $display("FAIL rst_mid_reach: rk_idx=%0d expected round 5", rk_idx); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || data_out !== 128'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: out_valid=%b data_out=%h busy=%b in_ready=%b expected 0/0/0/0", out_valid, data_out, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || rk_idx !== 4'd0) begin failures++; $display("FAIL rst_mid_idle: in_ready=%b rk_idx=%0d expected 1/0", in_ready, rk_idx); end
    rk10_tab = std10_rk;
    send_block(STD_PT);
    wait_out(15, got);
    checks++; if (!got || data_out !== CT128) begin failures++; $display("FAIL rst_mid_fresh: got %h valid=%b expected %h", data_out, got, CT128); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    bit got;
    bit extra;
    rk10_tab = apb_rk;
    send_block(APB_PT);
    tick();
    data_in  = STD_PT;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL ign_busy[%0d]: busy=%b in_ready=%b expected 1/0", i, busy, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    wait_out(15, got);
    checks++; if (!got || data_out !== APB_CT) begin failures++; $display("FAIL ign_ct: got %h valid=%b expected %h", data_out, got, APB_CT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      tick();
    end
    checks++; if (extra) begin failures++; $display("FAIL ign_no_extra: ignored input produced activity expected none"); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; data_in = 128'h0;
    iv12 = 1'b0; or12 = 1'b0; di12 = 128'h0;
    iv14 = 1'b0; or14 = 1'b0; di14 = 128'h0;
    apb_rk   = expand({APB_KEY, 128'h0}, 4);
    std10_rk = expand(K128, 4);
    std12_rk = expand(K192, 6);
    std14_rk = expand(K256, 8);
    rk10_tab = apb_rk;
    rk12_tab = std12_rk;
    rk14_tab = std14_rk;
    test_reset();
    test_fips_b();
    test_key_sizes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
